// File: rtl/s2c_pkt_streamer.sv
// Replays one parallel s2c result packet as an id/fn/data valid-ready word stream,
// flagging nonzero return codes and keeping packet/error counters.
module s2c_pkt_streamer #(
  parameter int NWORDS = 16,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_id,
  input  logic [DATA_W-1:0]        in_fn,
  input  logic [DATA_W-1:0]        in_ret,
  input  logic [4:0]               in_len,
  input  logic [NWORDS*DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_sof,
  output logic                     out_eof,
  output logic                     out_err,
  output logic                     busy,
  output logic [15:0]              pkt_cnt,
  output logic [15:0]              err_cnt
);
  localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  typedef enum logic [1:0] {IDLE, HDR_ID, HDR_FN, DATA} state_t;

  state_t                         state, state_nxt;
  logic [IW-1:0]                  idx, idx_nxt;
  logic [DATA_W-1:0]              id_q, fn_q;
  logic                           err_q;
  logic [4:0]                     len_q, len_clamp;
  logic [NWORDS-1:0][DATA_W-1:0]  words;
  logic                           accept, fire;

  assign len_clamp = (32'(in_len) > NWORDS) ? 5'(NWORDS) : in_len;
  assign in_ready  = (state == IDLE);
  assign busy      = ~in_ready;
  assign accept    = in_valid & in_ready;
  assign fire      = out_valid & out_ready;
  assign out_err   = out_eof & err_q;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    out_valid = 1'b0;
    out_data  = '0;
    out_sof   = 1'b0;
    out_eof   = 1'b0;
    case (state)
      IDLE: begin
        idx_nxt = '0;
        if (in_valid) state_nxt = HDR_ID;
      end
      HDR_ID: begin
        out_valid = 1'b1;
        out_data  = id_q;
        out_sof   = 1'b1;
        if (out_ready) state_nxt = HDR_FN;
      end
      HDR_FN: begin
        out_valid = 1'b1;
        out_data  = fn_q;
        // error packets drop their data words and end on the fn beat
        out_eof   = err_q | (len_q == 5'd0);
        if (out_ready) begin
          state_nxt = out_eof ? IDLE : DATA;
          idx_nxt   = '0;
        end
      end
      DATA: begin
        out_valid = 1'b1;
        out_data  = words[idx];
        out_eof   = (5'(idx) + 5'd1) == len_q;
        if (out_ready) begin
          state_nxt = out_eof ? IDLE : DATA;
          idx_nxt   = out_eof ? '0 : idx + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // payload registers need no reset: outputs are muxed to zero in IDLE
  always_ff @(posedge clk) begin
    if (accept) begin
      id_q  <= in_id;
      fn_q  <= in_fn;
      err_q <= |in_ret;
      len_q <= len_clamp;
      words <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt <= '0;
      err_cnt <= '0;
    end else if (fire && out_eof) begin
      pkt_cnt <= pkt_cnt + 16'd1;
      if (out_err && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end
endmodule
